// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: size encodings, FSM states and byte-lane helpers.
package mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  // Clear the offset bits below the access size (size 11 behaves as a word).
  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    logic [1:0] r;
    case (size)
      MEM_BYTE: r = off;
      MEM_HALF: r = {off[1], 1'b0};
      default:  r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic r;
    case (size)
      MEM_BYTE: r = 1'b0;
      MEM_HALF: r = off[0];
      default:  r = (off != 2'b00);
    endcase
    return r;
  endfunction

  // Byte enables for an already aligned offset.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] r;
    case (size)
      MEM_BYTE: r = BE_BYTE << off;
      MEM_HALF: r = off[1] ? BE_HALF_HI : BE_HALF_LO;
      default:  r = BE_WORD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte/halfword lane of the read word and
// sign- or zero-extends it to 32 bits. Words pass through unchanged.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{off, 3'b000} +: 8];
    half_lane = off[1] ? rdata[31:16] : rdata[15:0];
    data      = rdata;
    case (size)
      MEM_BYTE: data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
      MEM_HALF: data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Pipeline MEM stage with a registered ready/valid request to the memory controller.
// Define MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses with a bus error.
module mem_stage_hs
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_mem_readmem,
  input  logic              ex_mem_writemem,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_unsigned,
  input  logic [31:0]       ex_mem_regb,
  input  logic              ex_mem_selwsource,
  input  logic [REG_AW-1:0] ex_mem_regdest,
  input  logic              ex_mem_writereg,
  input  logic [31:0]       ex_mem_wbvalue,
  output logic              mem_mc_en,
  output logic              mem_mc_rw,
  output logic [ADDR_W-1:0] mem_mc_addr,
  output logic [3:0]        mem_mc_be,
  output logic [31:0]       mem_mc_wdata,
  input  logic [31:0]       mem_mc_rdata,
  input  logic              mem_mc_ready,
  output logic              mem_stall,
  output logic [REG_AW-1:0] mem_wb_regdest,
  output logic              mem_wb_writereg,
  output logic [31:0]       mem_wb_wbvalue,
  output logic              mem_bus_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                en_q, en_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          off_q, off_d;
  logic                uns_q, uns_d;
  logic [REG_AW-1:0]   wb_regdest_q, wb_regdest_d;
  logic                wb_writereg_q, wb_writereg_d;
  logic [31:0]         wb_wbvalue_q, wb_wbvalue_d;
  logic                bus_err_q, bus_err_d;

  logic                access;
  logic                align_err;
  logic [1:0]          off_eff;
  logic [31:0]         store_data;
  logic [31:0]         load_data;
  logic                timeout_hit;

  assign access      = ex_mem_readmem | ex_mem_writemem;
  assign off_eff     = align_off(ex_mem_size, ex_mem_wbvalue[1:0]);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef MEM_ALIGN_CHECK_EN
  assign align_err = is_misaligned(ex_mem_size, ex_mem_wbvalue[1:0]);
`else
  assign align_err = 1'b0;
`endif

  always_comb begin
    case (ex_mem_size)
      MEM_BYTE: store_data = {4{ex_mem_regb[7:0]}};
      MEM_HALF: store_data = {2{ex_mem_regb[15:0]}};
      default:  store_data = ex_mem_regb;
    endcase
  end

  // Alignment uses the attributes captured at request time, not the live EX/MEM copy.
  mem_load_align u_load_align (
    .rdata       (mem_mc_rdata),
    .off         (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (load_data)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    en_d          = en_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    size_d        = size_q;
    off_d         = off_q;
    uns_d         = uns_q;
    wb_regdest_d  = wb_regdest_q;
    wb_writereg_d = wb_writereg_q;
    wb_wbvalue_d  = wb_wbvalue_q;
    bus_err_d     = 1'b0;
    mem_stall     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!access) begin
          wb_regdest_d  = ex_mem_regdest;
          wb_writereg_d = ex_mem_writereg;
          wb_wbvalue_d  = ex_mem_wbvalue;
        end else if (align_err) begin
          wb_writereg_d = 1'b0;
          bus_err_d     = 1'b1;
        end else begin
          en_d          = 1'b1;
          rw_d          = ~ex_mem_readmem & ex_mem_writemem;
          addr_d        = ex_mem_wbvalue[ADDR_W+1:2];
          be_d          = lane_be(ex_mem_size, off_eff);
          wdata_d       = store_data;
          size_d        = ex_mem_size;
          off_d         = off_eff;
          uns_d         = ex_mem_unsigned;
          cnt_d         = '0;
          wb_writereg_d = 1'b0;
          mem_stall     = 1'b1;
          state_d       = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_mc_ready) begin
          en_d          = 1'b0;
          state_d       = S_IDLE;
          wb_regdest_d  = ex_mem_regdest;
          wb_writereg_d = ex_mem_writereg;
          wb_wbvalue_d  = ex_mem_selwsource ? load_data : ex_mem_wbvalue;
        end else if (timeout_hit) begin
          en_d          = 1'b0;
          state_d       = S_IDLE;
          bus_err_d     = 1'b1;
          wb_writereg_d = 1'b0;
        end else begin
          cnt_d         = cnt_q + CNT_W'(1);
          wb_writereg_d = 1'b0;
          mem_stall     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      en_q          <= 1'b0;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      size_q        <= '0;
      off_q         <= '0;
      uns_q         <= 1'b0;
      wb_regdest_q  <= '0;
      wb_writereg_q <= 1'b0;
      wb_wbvalue_q  <= '0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      en_q          <= en_d;
      rw_q          <= rw_d;
      addr_q        <= addr_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      size_q        <= size_d;
      off_q         <= off_d;
      uns_q         <= uns_d;
      wb_regdest_q  <= wb_regdest_d;
      wb_writereg_q <= wb_writereg_d;
      wb_wbvalue_q  <= wb_wbvalue_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign mem_mc_en       = en_q;
  assign mem_mc_rw       = rw_q;
  assign mem_mc_addr     = addr_q;
  assign mem_mc_be       = be_q;
  assign mem_mc_wdata    = wdata_q;
  assign mem_wb_regdest  = wb_regdest_q;
  assign mem_wb_writereg = wb_writereg_q;
  assign mem_wb_wbvalue  = wb_wbvalue_q;
  assign mem_bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Randomized bench for mem_stage_hs against a byte-array memory model with a
// variable-latency responder; honours MEM_ALIGN_CHECK_EN when defined.
module tb_mem_stage_hs;

  localparam int ADDR_W  = 18;
  localparam int REG_AW  = 5;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_mem_readmem, ex_mem_writemem, ex_mem_unsigned;
  logic [1:0]        ex_mem_size;
  logic [31:0]       ex_mem_regb, ex_mem_wbvalue;
  logic              ex_mem_selwsource, ex_mem_writereg;
  logic [REG_AW-1:0] ex_mem_regdest;
  logic              mem_mc_en, mem_mc_rw, mem_mc_ready, mem_stall;
  logic [ADDR_W-1:0] mem_mc_addr;
  logic [3:0]        mem_mc_be;
  logic [31:0]       mem_mc_wdata, mem_mc_rdata;
  logic [REG_AW-1:0] mem_wb_regdest;
  logic              mem_wb_writereg, mem_bus_err;
  logic [31:0]       mem_wb_wbvalue;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;
  logic [7:0] mem_m [64];

  always #5 clk = ~clk;

  mem_stage_hs #(.ADDR_W(ADDR_W), .REG_AW(REG_AW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clk), .reset(rst),
    .ex_mem_readmem(ex_mem_readmem), .ex_mem_writemem(ex_mem_writemem),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
    .ex_mem_regb(ex_mem_regb), .ex_mem_selwsource(ex_mem_selwsource),
    .ex_mem_regdest(ex_mem_regdest), .ex_mem_writereg(ex_mem_writereg),
    .ex_mem_wbvalue(ex_mem_wbvalue),
    .mem_mc_en(mem_mc_en), .mem_mc_rw(mem_mc_rw), .mem_mc_addr(mem_mc_addr),
    .mem_mc_be(mem_mc_be), .mem_mc_wdata(mem_mc_wdata),
    .mem_mc_rdata(mem_mc_rdata), .mem_mc_ready(mem_mc_ready),
    .mem_stall(mem_stall),
    .mem_wb_regdest(mem_wb_regdest), .mem_wb_writereg(mem_wb_writereg),
    .mem_wb_wbvalue(mem_wb_wbvalue), .mem_bus_err(mem_bus_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle_inputs();
    ex_mem_readmem    = 1'b0;
    ex_mem_writemem   = 1'b0;
    ex_mem_size       = 2'b00;
    ex_mem_unsigned   = 1'b0;
    ex_mem_regb       = '0;
    ex_mem_selwsource = 1'b0;
    ex_mem_regdest    = '0;
    ex_mem_writereg   = 1'b0;
    ex_mem_wbvalue    = '0;
    mem_mc_ready      = 1'b0;
    mem_mc_rdata      = '0;
  endtask

  // Non-memory instruction: one-cycle pass-through; a stray ready must be ignored.
  task automatic idle_txn();
    @(negedge clk);
    drive_idle_inputs();
    ex_mem_regdest  = REG_AW'($urandom);
    ex_mem_writereg = 1'($urandom);
    ex_mem_wbvalue  = $urandom;
    mem_mc_ready    = 1'($urandom);
    mem_mc_rdata    = $urandom;
    #1 check_eq("idle_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    check_eq("idle_en", 32'(mem_mc_en), 32'd0);
    check_eq("idle_wreg", 32'(mem_wb_writereg), 32'(ex_mem_writereg));
    check_eq("idle_rdst", 32'(mem_wb_regdest), 32'(ex_mem_regdest));
    check_eq("idle_wbv", mem_wb_wbvalue, ex_mem_wbvalue);
    check_eq("idle_err", 32'(mem_bus_err), 32'd0);
    mem_mc_ready = 1'b0;
    $display("txn %0d: alu wb=%h", n_txn, ex_mem_wbvalue);
    n_txn++;
  endtask

  // Memory instruction with the responder answering after `delay` BUSY cycles.
  task automatic access_txn(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic sel, input logic [31:0] regb,
                            input logic [31:0] wbv, input int delay);
    int n, a, a_al, base;
    logic misal, is_st;
    logic [31:0] exp_ld, exp_wd, word;
    logic [3:0]  exp_be;
    logic [ADDR_W-1:0] exp_addr;
    n     = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    a     = int'(wbv[5:0]);
    a_al  = a - (a % n);
    base  = a - (a % 4);
    misal = (a % n) != 0;
    is_st = !rd && wr;
    exp_be   = 4'(((1 << n) - 1) << (a_al % 4));
    exp_wd   = (n == 1) ? {4{regb[7:0]}} : (n == 2) ? {2{regb[15:0]}} : regb;
    exp_addr = wbv[ADDR_W+1:2];
    exp_ld = '0;
    for (int i = 0; i < n; i++) exp_ld |= 32'(mem_m[a_al+i]) << (8 * i);
    if (!uns && n < 4 && exp_ld[8*n-1]) exp_ld |= 32'hFFFF_FFFF << (8 * n);
    word = {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};

    @(negedge clk);
    drive_idle_inputs();
    ex_mem_readmem    = rd;
    ex_mem_writemem   = wr;
    ex_mem_size       = sz;
    ex_mem_unsigned   = uns;
    ex_mem_selwsource = sel;
    ex_mem_regb       = regb;
    ex_mem_wbvalue    = wbv;
    ex_mem_regdest    = REG_AW'($urandom);
    ex_mem_writereg   = 1'($urandom);
`ifdef MEM_ALIGN_CHECK_EN
    if (misal) begin
      #1 check_eq("mis_stall", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      check_eq("mis_en", 32'(mem_mc_en), 32'd0);
      check_eq("mis_err", 32'(mem_bus_err), 32'd1);
      check_eq("mis_wreg", 32'(mem_wb_writereg), 32'd0);
      $display("txn %0d: misaligned sz=%0d addr=%h -> bus error", n_txn, sz, wbv);
      n_txn++;
      return;
    end
`endif
    #1 check_eq("req_stall", 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    check_eq("req_en", 32'(mem_mc_en), 32'd1);
    check_eq("req_rw", 32'(mem_mc_rw), 32'(is_st));
    check_eq("req_addr", 32'(mem_mc_addr), 32'(exp_addr));
    check_eq("req_be", 32'(mem_mc_be), 32'(exp_be));
    check_eq("req_wdata", mem_mc_wdata, exp_wd);
    check_eq("req_wreg", 32'(mem_wb_writereg), 32'd0);
    check_eq("req_err", 32'(mem_bus_err), 32'd0);
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      if (k == delay) begin
        mem_mc_ready = 1'b1;
        mem_mc_rdata = word;
        #1 check_eq("done_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        check_eq("done_en", 32'(mem_mc_en), 32'd0);
        check_eq("done_wreg", 32'(mem_wb_writereg), 32'(ex_mem_writereg));
        check_eq("done_rdst", 32'(mem_wb_regdest), 32'(ex_mem_regdest));
        check_eq("done_wbv", mem_wb_wbvalue, sel ? exp_ld : wbv);
        check_eq("done_err", 32'(mem_bus_err), 32'd0);
        mem_mc_ready = 1'b0;
        if (is_st) for (int i = 0; i < n; i++) mem_m[a_al+i] = regb[8*i +: 8];
        $display("txn %0d: %s sz=%0d addr=%h delay=%0d wb=%h", n_txn,
                 is_st ? "store" : "load", sz, wbv, delay, mem_wb_wbvalue);
        break;
      end else if (k == TIMEOUT - 1) begin
        mem_mc_rdata = $urandom;
        #1 check_eq("to_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        check_eq("to_en", 32'(mem_mc_en), 32'd0);
        check_eq("to_err", 32'(mem_bus_err), 32'd1);
        check_eq("to_wreg", 32'(mem_wb_writereg), 32'd0);
        $display("txn %0d: %s sz=%0d addr=%h timeout", n_txn,
                 is_st ? "store" : "load", sz, wbv);
      end else begin
        mem_mc_rdata = $urandom;
        #1 check_eq("wait_stall", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        check_eq("wait_en", 32'(mem_mc_en), 32'd1);
        check_eq("wait_addr", 32'(mem_mc_addr), 32'(exp_addr));
        check_eq("wait_be", 32'(mem_mc_be), 32'(exp_be));
        check_eq("wait_wreg", 32'(mem_wb_writereg), 32'd0);
        check_eq("wait_err", 32'(mem_bus_err), 32'd0);
      end
    end
    n_txn++;
  endtask

  task automatic reset_in_busy();
    @(negedge clk);
    drive_idle_inputs();
    ex_mem_readmem = 1'b1;
    ex_mem_size    = 2'b10;
    ex_mem_wbvalue = 32'h0000_0010;
    ex_mem_writereg = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_req_en", 32'(mem_mc_en), 32'd1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_eq("rst_en", 32'(mem_mc_en), 32'd0);
    check_eq("rst_wreg", 32'(mem_wb_writereg), 32'd0);
    check_eq("rst_err", 32'(mem_bus_err), 32'd0);
    drive_idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    $display("txn %0d: reset during busy", n_txn);
    n_txn++;
  endtask

  initial begin
    logic rd, wr;
    for (int i = 0; i < 64; i++) mem_m[i] = 8'($urandom);
    drive_idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_en0", 32'(mem_mc_en), 32'd0);
    check_eq("rst_be0", 32'(mem_mc_be), 32'd0);
    check_eq("rst_wbv0", mem_wb_wbvalue, 32'd0);
    check_eq("rst_wreg0", 32'(mem_wb_writereg), 32'd0);
    check_eq("rst_err0", 32'(mem_bus_err), 32'd0);
    check_eq("rst_stall0", 32'(mem_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    access_txn(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100, 0);
    access_txn(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0, 32'h0000_0100, 0);
    check_eq("dir_lw", mem_wb_wbvalue, 32'hDEAD_BEEF);
    mem_m[0] = 8'h00; mem_m[1] = 8'h80; mem_m[2] = 8'h00; mem_m[3] = 8'h00;
    access_txn(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 32'h0000_0101, 0);
    check_eq("dir_lb_s", mem_wb_wbvalue, 32'hFFFF_FF80);
    access_txn(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0, 32'h0000_0101, 1);
    check_eq("dir_lb_u", mem_wb_wbvalue, 32'h0000_0080);
    access_txn(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_0102, 0);
    access_txn(1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 32'h0, 32'h0000_0102, 3);
    check_eq("dir_lh", mem_wb_wbvalue, 32'h0000_1234);
    access_txn(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0, 32'h0000_0104, 10);
    idle_txn();
    reset_in_busy();
    access_txn(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0, 32'h0000_0010, 1);
    access_txn(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0, 32'h0000_0102, 0);

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 9) < 4) begin
        idle_txn();
      end else begin
        rd = 1'($urandom);
        wr = 1'($urandom);
        if (!rd && !wr) rd = 1'b1;
        access_txn(rd, wr, 2'($urandom), 1'($urandom), 1'($urandom), $urandom,
                   {12'($urandom), 14'd0, 6'($urandom)}, $urandom_range(0, 5));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
